// File: rtl/mips_rf_multiport_pkg.sv
// rtl/mips_rf_multiport_pkg.sv - shared types and defaults for the multiport register file
//
// Purpose: clear-engine state encoding and default geometry constants.
// Ports:   none (package).

package mips_rf_multiport_pkg;

  localparam int DEF_AWL = 5;
  localparam int DEF_DWL = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_clr_state_e;

endpackage

// File: rtl/mips_rf_multiport_rf_clear_fsm.sv
// rtl/mips_rf_multiport_rf_clear_fsm.sv - full-array clear sequencer for the register file
//
// Purpose: walks every register address once, one per cycle, emitting a
//          clear enable/address pair; entered on reset or on a clear request.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (forces a fresh clear)
//   clr_req_i   single-cycle clear request, honoured only when idle
//   busy_o      high for the whole clear sequence
//   clr_en_o    array clear write enable for this cycle
//   clr_addr_o  array address cleared this cycle

module rf_clear_fsm
  import mips_rf_multiport_pkg::*;
#(
  parameter int AWL = DEF_AWL
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_req_i,
  output logic           busy_o,
  output logic           clr_en_o,
  output logic [AWL-1:0] clr_addr_o
);

  rf_clr_state_e  state_q;
  logic [AWL-1:0] cnt_q;
  logic           busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // Reset (including mid-clear) always restarts the sweep from entry 0.
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // The edge that clears the last entry drops busy; the counter
          // never wraps back to 0 inside a sweep.
          if (cnt_q == '1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_en_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/mips_rf_multiport.sv
// rtl/mips_rf_multiport.sv - two-write, NRD-read register file with forwarding and clear engine
//
// Purpose: 2**AWL x DWL register array, combinational reads, two write
//          ports (port 1 wins on address collision), optional write-to-read
//          forwarding, optional hardwired zero register, full-array clear.
// Ports:
//   clk                  clock
//   rst_n                synchronous active-low reset (starts a clear)
//   WE0/RFWA0/RFWD0      write port 0 enable/address/data
//   WE1/RFWA1/RFWD1      write port 1 enable/address/data
//   raddr                packed read addresses, port k at [k*AWL +: AWL]
//   rdata                packed read data, port k at [k*DWL +: DWL]
//   clr_req              clear request pulse
//   busy                 clear in progress (writes ignored, reads return 0)

module mips_rf_multiport
  import mips_rf_multiport_pkg::*;
#(
  parameter int AWL      = DEF_AWL,
  parameter int DWL      = DEF_DWL,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               WE0,
  input  logic [AWL-1:0]     RFWA0,
  input  logic [DWL-1:0]     RFWD0,
  input  logic               WE1,
  input  logic [AWL-1:0]     RFWA1,
  input  logic [DWL-1:0]     RFWD1,
  input  logic [NRD*AWL-1:0] raddr,
  output logic [NRD*DWL-1:0] rdata,
  input  logic               clr_req,
  output logic               busy
);

  localparam int DEPTH = 1 << AWL;

  logic [DWL-1:0] mem_q [DEPTH];

  logic           clr_en;
  logic [AWL-1:0] clr_addr;

  logic           we0_ok;
  logic           we1_ok;
  logic [AWL-1:0] rd_addr;
  logic [DWL-1:0] rd_val;

  rf_clear_fsm #(
    .AWL (AWL)
  ) u_clear (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_req_i  (clr_req),
    .busy_o     (busy),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  // A write is effective only outside a clear and never to the zero register;
  // the same qualified enables gate forwarding so address 0 is never bypassed.
  assign we0_ok = WE0 && !busy && !((ZERO_REG != 0) && (RFWA0 == '0));
  assign we1_ok = WE1 && !busy && !((ZERO_REG != 0) && (RFWA1 == '0));

  // Port 1 is written last so it overrides port 0 on an address collision.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (we0_ok) mem_q[RFWA0] <= RFWD0;
      if (we1_ok) mem_q[RFWA1] <= RFWD1;
    end
  end

  always_comb begin
    rdata   = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr = raddr[k*AWL +: AWL];
      rd_val  = mem_q[rd_addr];
      if (BYPASS != 0) begin
        if (we1_ok && (RFWA1 == rd_addr)) begin
          rd_val = RFWD1;
        end else if (we0_ok && (RFWA0 == rd_addr)) begin
          rd_val = RFWD0;
        end
      end
      if (busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
        rd_val = '0;
      end
      rdata[k*DWL +: DWL] = rd_val;
    end
  end

endmodule

// File: tb/tb_mips_rf_multiport.sv
// tb/tb_mips_rf_multiport.sv - self-checking bench for mips_rf_multiport

module tb_mips_rf_multiport;

  localparam int AWL   = 5;
  localparam int DWL   = 16;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               WE0, WE1;
  logic [AWL-1:0]     RFWA0, RFWA1;
  logic [DWL-1:0]     RFWD0, RFWD1;
  logic [NRD*AWL-1:0] raddr;
  logic [NRD*DWL-1:0] rdata;
  logic               clr_req;
  logic               busy;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: array contents plus remaining clear cycles.
  logic [DWL-1:0] mem_m [DEPTH];
  int             clr_left = 0;

  always #5 clk = ~clk;

  mips_rf_multiport #(
    .AWL(AWL), .DWL(DWL), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .WE0(WE0), .RFWA0(RFWA0), .RFWD0(RFWD0),
    .WE1(WE1), .RFWA1(RFWA1), .RFWD1(RFWD1),
    .raddr(raddr), .rdata(rdata),
    .clr_req(clr_req), .busy(busy)
  );

  function automatic logic [DWL-1:0] exp_read(input logic [AWL-1:0] a);
    if (clr_left > 0 || a == 0) return '0;
    if (WE1 && RFWA1 == a) return RFWD1;
    if (WE0 && RFWA0 == a) return RFWD0;
    return mem_m[a];
  endfunction

  // Update the model for the coming edge, then move just past that edge.
  task automatic advance();
    if (!rst_n) begin
      clr_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (WE0 && RFWA0 != 0) mem_m[RFWA0] = RFWD0;
      if (WE1 && RFWA1 != 0) mem_m[RFWA1] = RFWD1;
      if (clr_req) begin
        clr_left = DEPTH;
        foreach (mem_m[i]) mem_m[i] = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE0 = 0; WE1 = 0; RFWA0 = 0; RFWA1 = 0; RFWD0 = 0; RFWD1 = 0; clr_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    raddr = 0;
    advance();
    advance();
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      raddr = {5'($urandom), 5'($urandom)};
      #1;
      n_total++;
      if (busy !== 1'b1) $display("FAIL reset_busy cyc=%0d got=%b exp=1", i, busy);
      else n_pass++;
      n_total++;
      if (rdata !== '0) $display("FAIL reset_rdata cyc=%0d got=%h exp=0", i, rdata);
      else n_pass++;
      advance();
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy_fall got=%b exp=0", busy);
    else n_pass++;
    for (int a = 0; a < DEPTH; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      #1;
      n_total++;
      if (rdata !== '0) $display("FAIL reset_contents addr=%0d got=%h exp=0", a, rdata);
      else n_pass++;
    end
  endtask

  task automatic test_write_conflict();
    WE0 = 1; RFWA0 = 3; RFWD0 = 16'h1234;
    WE1 = 1; RFWA1 = 3; RFWD1 = 16'hBEEF;
    advance();
    idle_inputs();
    raddr = {5'd2, 5'd3};
    #1;
    n_total++;
    if (rdata[15:0] !== 16'hBEEF) $display("FAIL conflict_port1_wins got=%h exp=beef", rdata[15:0]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    WE1 = 1; RFWA1 = 7; RFWD1 = 16'hA5A5;
    raddr = {5'd7, 5'd7};
    #1;
    n_total++;
    if (rdata[31:16] !== 16'hA5A5) $display("FAIL bypass_p1 got=%h exp=a5a5", rdata[31:16]);
    else n_pass++;
    n_total++;
    if (rdata[15:0] !== 16'hA5A5) $display("FAIL bypass_p0 got=%h exp=a5a5", rdata[15:0]);
    else n_pass++;
    advance();
    idle_inputs();
    #1;
    n_total++;
    if (rdata[31:16] !== 16'hA5A5) $display("FAIL bypass_stored got=%h exp=a5a5", rdata[31:16]);
    else n_pass++;
    WE0 = 1; RFWA0 = 12; RFWD0 = 16'h1111;
    WE1 = 1; RFWA1 = 12; RFWD1 = 16'h2222;
    raddr = {5'd12, 5'd12};
    #1;
    n_total++;
    if (rdata !== {16'h2222, 16'h2222}) $display("FAIL bypass_both_match got=%h exp=22222222", rdata);
    else n_pass++;
    RFWA0 = 13; RFWD0 = 16'h3333;
    RFWA1 = 14; RFWD1 = 16'h4444;
    raddr = {5'd14, 5'd13};
    #1;
    n_total++;
    if (rdata !== {16'h4444, 16'h3333}) $display("FAIL bypass_split got=%h exp=44443333", rdata);
    else n_pass++;
    advance();
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    WE0 = 1; RFWA0 = 0; RFWD0 = 16'hFFFF;
    WE1 = 1; RFWA1 = 0; RFWD1 = 16'hFFFF;
    raddr = {5'd0, 5'd0};
    #1;
    n_total++;
    if (rdata !== '0) $display("FAIL zero_same_cycle got=%h exp=0", rdata);
    else n_pass++;
    advance();
    idle_inputs();
    #1;
    n_total++;
    if (rdata !== '0) $display("FAIL zero_after got=%h exp=0", rdata);
    else n_pass++;
  endtask

  task automatic test_clear_blocks_writes();
    WE0 = 1; RFWA0 = 9; RFWD0 = 16'h0042;
    advance();
    idle_inputs();
    raddr = {5'd9, 5'd9};
    #1;
    n_total++;
    if (rdata[15:0] !== 16'h0042) $display("FAIL clear_prefill got=%h exp=0042", rdata[15:0]);
    else n_pass++;
    clr_req = 1;
    WE1 = 1; RFWA1 = 5; RFWD1 = 16'h1111;
    advance();
    idle_inputs();
    raddr = {5'd5, 5'd9};
    for (int i = 0; i < DEPTH; i++) begin
      WE0 = (i == 10); RFWA0 = 9; RFWD0 = 16'h7777;
      WE1 = (i == 11); RFWA1 = 5; RFWD1 = 16'h8888;
      clr_req = (i == 20);
      #1;
      n_total++;
      if (busy !== 1'b1) $display("FAIL clear_busy cyc=%0d got=%b exp=1", i, busy);
      else n_pass++;
      n_total++;
      if (rdata !== '0) $display("FAIL clear_rdata cyc=%0d got=%h exp=0", i, rdata);
      else n_pass++;
      advance();
    end
    idle_inputs();
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL clear_busy_fall got=%b exp=0", busy);
    else n_pass++;
    n_total++;
    if (rdata !== '0) $display("FAIL clear_erased got=%h exp=0", rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    WE0 = 1; RFWA0 = 4; RFWD0 = 16'hABCD;
    advance();
    idle_inputs();
    clr_req = 1;
    advance();
    clr_req = 0;
    repeat (20) advance();
    rst_n = 0;
    advance();
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (busy !== 1'b1) $display("FAIL midclr_busy cyc=%0d got=%b exp=1", i, busy);
      else n_pass++;
      advance();
    end
    raddr = {5'd4, 5'd4};
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL midclr_busy_fall got=%b exp=0", busy);
    else n_pass++;
    n_total++;
    if (rdata !== '0) $display("FAIL midclr_erased got=%h exp=0", rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AWL-1:0] a;
    for (int i = 0; i < 400; i++) begin
      WE0 = 1'($urandom); RFWA0 = 5'($urandom_range(0, 15)); RFWD0 = 16'($urandom);
      WE1 = 1'($urandom); RFWA1 = 5'($urandom_range(0, 15)); RFWD1 = 16'($urandom);
      clr_req = ($urandom_range(0, 149) == 0);
      raddr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      #1;
      n_total++;
      if (busy !== (clr_left > 0)) $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, clr_left > 0);
      else n_pass++;
      for (int k = 0; k < NRD; k++) begin
        a = raddr[k*AWL +: AWL];
        n_total++;
        if (rdata[k*DWL +: DWL] !== exp_read(a))
          $display("FAIL rand_read cyc=%0d port=%0d addr=%0d got=%h exp=%h", i, k, a, rdata[k*DWL +: DWL], exp_read(a));
        else n_pass++;
      end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_conflict();
    test_bypass();
    test_zero_reg();
    test_clear_blocks_writes();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
